inv_nibble_rx: RTL

Tiny Tapeout user module that receives bytes as pairs of active-low nibbles on the 8-bit input pins, restores true polarity, and buffers them in a small FIFO. The host reads each byte back a nibble at a time on the output pins. It is the receive/decode end of the active-low inverted-pin drive used by the team's inverter-array user modules, and sits directly on the standard `io_in`/`io_out` scan-chain slot.

---
 rtl/inv_nibble_pkg.sv | 28 ++
 rtl/sync_fifo_byte.sv | 62 ++++++
 rtl/inv_nibble_rx.sv | 100 ++++++++++
 3 files changed

// File: rtl/inv_nibble_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inv_nibble_pkg: shared constants for the active-low nibble receiver. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package inv_nibble_pkg;

    localparam int DEFAULT_DEPTH = 4;

    // io_in pin indices
    localparam int CLK   = 0;
    localparam int RST   = 1;
    localparam int WR_N  = 2;
    localparam int RD_N  = 3;
    localparam int D_LSB = 4;

    // io_out bit indices
    localparam int NIB_SEL = 4;
    localparam int EMPTY   = 5;
    localparam int FULL    = 6;
    localparam int OVF     = 7;

    function automatic logic [3:0] true_nibble(input logic [3:0] d_n);
        return ~d_n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_byte.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo_byte: single-clock byte FIFO with count-based full/empty.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_fifo_byte #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/inv_nibble_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inv_nibble_rx: assembles active-low nibble pairs into bytes, buffers |
// | them and presents the head byte one nibble at a time. Rev 1.0        |
// +----------------------------------------------------------------------+
module inv_nibble_rx
    import inv_nibble_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);
    logic       clk;
    logic       rst;
    logic       wr_n;
    logic       rd_n;
    logic [3:0] nib_in;

    assign clk    = io_in[CLK];
    assign rst    = io_in[RST];
    assign wr_n   = io_in[WR_N];
    assign rd_n   = io_in[RD_N];
    assign nib_in = true_nibble(io_in[D_LSB +: 4]);

    logic       wr_prev;
    logic       rd_prev;
    logic       half;
    logic [3:0] hi_nib;
    logic       nib_sel;
    logic       overflow;

    logic       wr_fire;
    logic       rd_fire;
    logic       push;
    logic       pop;
    logic [7:0] push_byte;
    logic [7:0] head;
    logic       full;
    logic       empty;

    assign wr_fire   = wr_prev & ~wr_n;
    assign rd_fire   = rd_prev & ~rd_n;
    assign push      = wr_fire & half;
    assign push_byte = {hi_nib, nib_in};
    assign pop       = rd_fire & nib_sel & ~empty;

    sync_fifo_byte #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_byte),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Previous-sample registers clear to 0 so a strobe held low across reset stays silent.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_prev  <= 1'b0;
            rd_prev  <= 1'b0;
            half     <= 1'b0;
            hi_nib   <= 4'h0;
            nib_sel  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_prev <= wr_n;
            rd_prev <= rd_n;
            if (wr_fire) begin
                if (half) begin
                    half <= 1'b0;
                end else begin
                    hi_nib <= nib_in;
                    half   <= 1'b1;
                end
            end
            if (rd_fire && !empty) begin
                nib_sel <= ~nib_sel;
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        io_out          = 8'h00;
        io_out[3:0]     = empty ? 4'h0 : (nib_sel ? head[3:0] : head[7:4]);
        io_out[NIB_SEL] = nib_sel;
        io_out[EMPTY]   = empty;
        io_out[FULL]    = full;
        io_out[OVF]     = overflow;
    end

endmodule
`default_nettype wire
